// File: rtl/mul_pkg.sv
// mul_pkg: shared constants, opcode/state encodings and operand signedness helper
// for the sequential RV32M multiply block.
package mul_pkg;

    localparam int XLEN   = 32;
    localparam int HALF_W = XLEN / 2;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    // Returns {rs1 treated as signed, rs2 treated as signed} for an opcode.
    function automatic logic [1:0] sign_class(input logic [1:0] op);
        logic [1:0] cls;
        cls = 2'b00;
        case (op)
            OP_MULH:   cls = 2'b11;
            OP_MULHSU: cls = 2'b10;
            default:   cls = 2'b00;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mul16x16_u.sv
// mul16x16_u: purely combinational unsigned HALF_W x HALF_W -> XLEN multiplier,
// shared by every partial-product step of the sequencer.
module mul16x16_u
    import mul_pkg::*;
(
    input  logic [HALF_W-1:0] i_a,
    input  logic [HALF_W-1:0] i_b,
    output logic [XLEN-1:0]   o_p
);

    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;

    assign w_a_ext = {{HALF_W{1'b0}}, i_a};
    assign w_b_ext = {{HALF_W{1'b0}}, i_b};
    assign o_p     = w_a_ext * w_b_ext;

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: RV32M MUL/MULH/MULHSU/MULHU sequencer built on one 16x16 unsigned multiplier.
// Define MUL_RESULT_CACHE_EN to add a last-result cache that short-circuits repeated operands.
module mul_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] A_i,
    input  logic [XLEN-1:0] B_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] writeback_value_o,
    output logic            busy_o
);
    import mul_pkg::*;

    localparam int ACC_W = 2 * XLEN;

    if (XLEN != 32) begin : g_xlen_check
        $error("mul_seq_ctrl: only XLEN = 32 is supported");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic [1:0]         r_cnt;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic [1:0]         r_op;
    logic               r_neg;
    logic [ACC_W-1:0]   r_acc;
    logic               r_req_ready;

    logic               w_accept;
    logic [1:0]         w_class;
    logic               w_sa;
    logic               w_sb;
    logic [XLEN-1:0]    w_abs_a;
    logic [XLEN-1:0]    w_abs_b;
    logic               w_hit;
    logic [ACC_W-1:0]   w_hit_prod;
    logic [HALF_W-1:0]  w_mul_a;
    logic [HALF_W-1:0]  w_mul_b;
    logic [XLEN-1:0]    w_pp;
    logic [ACC_W-1:0]   w_pp_ext;
    logic [ACC_W-1:0]   w_acc_fixed;

    assign w_accept = req_valid_i & r_req_ready;
    assign w_class  = sign_class(op_i);
    assign w_sa     = w_class[1] & A_i[XLEN-1];
    assign w_sb     = w_class[0] & B_i[XLEN-1];
    // Two's-complement negation of 0x80000000 wraps to itself, which is the correct unsigned magnitude.
    assign w_abs_a  = w_sa ? (~A_i + 1'b1) : A_i;
    assign w_abs_b  = w_sb ? (~B_i + 1'b1) : B_i;

    assign w_mul_a = r_cnt[0] ? r_a[XLEN-1:HALF_W] : r_a[HALF_W-1:0];
    assign w_mul_b = r_cnt[1] ? r_b[XLEN-1:HALF_W] : r_b[HALF_W-1:0];

    mul16x16_u u_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_pp)
    );

    always_comb begin
        w_pp_ext = '0;
        case (r_cnt)
            2'd0:    w_pp_ext = {{XLEN{1'b0}}, w_pp};
            2'd1,
            2'd2:    w_pp_ext = {{HALF_W{1'b0}}, w_pp, {HALF_W{1'b0}}};
            default: w_pp_ext = {w_pp, {XLEN{1'b0}}};
        endcase
    end

    assign w_acc_fixed = r_neg ? (~r_acc + 1'b1) : r_acc;

`ifdef MUL_RESULT_CACHE_EN
    logic               r_cache_valid;
    logic [XLEN-1:0]    r_cache_a;
    logic [XLEN-1:0]    r_cache_b;
    logic [1:0]         r_cache_class;
    logic [ACC_W-1:0]   r_cache_prod;
    logic [XLEN-1:0]    r_a_raw;
    logic [XLEN-1:0]    r_b_raw;
    logic [1:0]         r_class;

    // MUL returns the low word, which is identical for every signedness class.
    assign w_hit = r_cache_valid && (A_i == r_cache_a) && (B_i == r_cache_b) &&
                   ((op_i == OP_MUL) || (w_class == r_cache_class));
    assign w_hit_prod = r_cache_prod;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cache_valid <= 1'b0;
            r_cache_a     <= '0;
            r_cache_b     <= '0;
            r_cache_class <= 2'b00;
            r_cache_prod  <= '0;
            r_a_raw       <= '0;
            r_b_raw       <= '0;
            r_class       <= 2'b00;
        end else begin
            if ((r_state == S_IDLE) && w_accept) begin
                r_a_raw <= A_i;
                r_b_raw <= B_i;
                r_class <= w_class;
            end
            if (r_state == S_SIGN) begin
                r_cache_valid <= 1'b1;
                r_cache_a     <= r_a_raw;
                r_cache_b     <= r_b_raw;
                r_cache_class <= r_class;
                r_cache_prod  <= w_acc_fixed;
            end
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_prod = '0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = w_hit ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == 2'd3) w_next_state = S_SIGN;
            S_SIGN: w_next_state = S_DONE;
            S_DONE: if (resp_ready_i) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_ready <= 1'b0;
            r_cnt       <= 2'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_MUL;
            r_neg       <= 1'b0;
            r_acc       <= '0;
        end else begin
            r_req_ready <= (w_next_state == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= w_abs_a;
                        r_b   <= w_abs_b;
                        r_op  <= op_i;
                        r_neg <= w_sa ^ w_sb;
                        r_cnt <= 2'd0;
                        r_acc <= w_hit ? w_hit_prod : '0;
                    end
                end
                S_CALC: begin
                    r_acc <= r_acc + w_pp_ext;
                    r_cnt <= r_cnt + 2'd1;
                end
                S_SIGN: begin
                    r_acc <= w_acc_fixed;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready_o       = r_req_ready;
    assign resp_valid_o      = (r_state == S_DONE);
    assign busy_o            = (r_state != S_IDLE);
    assign writeback_value_o = (r_state != S_DONE) ? '0 :
                               (r_op == OP_MUL)    ? r_acc[XLEN-1:0] : r_acc[ACC_W-1:XLEN];

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: scoreboard bench for mul_seq_ctrl; expected results and response
// cycles are queued at request acceptance and compared when the response first appears.
module tb_mul_seq_ctrl;
    import mul_pkg::*;

`ifdef MUL_RESULT_CACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 6;
`endif
    localparam int FULL_LAT = 6;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  op_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] writeback_value_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] value;
        int          cycle;
    } expect_t;

    expect_t scoreboard[$];
    int      cyc = 0;
    int      vectorCount = 0;
    int      missCount = 0;
    logic    respSeen = 1'b0;

    mul_seq_ctrl #(.XLEN(32)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .op_i              (op_i),
        .A_i               (A_i),
        .B_i               (B_i),
        .resp_valid_o      (resp_valid_o),
        .resp_ready_i      (resp_ready_i),
        .writeback_value_o (writeback_value_o),
        .busy_o            (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Reference result from sign/zero-extended 64-bit operands.
    function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = {{32{((op == OP_MULH) || (op == OP_MULHSU)) && a[31]}}, a};
        eb = {{32{(op == OP_MULH) && b[31]}}, b};
        p  = ea * eb;
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            respSeen = 1'b0;
        end else if (resp_valid_o) begin
            if (!respSeen) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("unexpected_resp", resp_valid_o, 1'b0);
                end else begin
                    expect_t e;
                    e = scoreboard.pop_front();
                    checkOutput("result", writeback_value_o, e.value);
                    checkOutput("resp_cycle", cyc, e.cycle);
                end
            end
            respSeen = !resp_ready_i;
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input int lat, output int acceptCyc);
        int guard;
        bit accepted;
        expect_t e;
        req_valid_i = 1'b1;
        op_i        = op;
        A_i         = a;
        B_i         = b;
        accepted    = 1'b0;
        acceptCyc   = -1;
        guard       = 0;
        while (!accepted && guard < 60) begin
            if (req_ready_o) begin
                accepted  = 1'b1;
                acceptCyc = cyc;
                e.value   = exp;
                e.cycle   = cyc + lat;
                scoreboard.push_back(e);
            end
            @(negedge clk_i);
            guard++;
        end
        if (!accepted) checkOutput("req_accept", req_ready_o, 1'b1);
        req_valid_i = 1'b0;
        op_i        = 2'($urandom_range(0, 3));
        A_i         = $urandom;
        B_i         = $urandom;
    endtask

    task automatic drainResponses();
        int guard;
        guard = 0;
        while ((scoreboard.size() != 0 || busy_o) && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 100) begin
            checkOutput("drain_busy", busy_o, 1'b0);
            checkOutput("drain_pending", scoreboard.size(), 0);
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c1;
        int c2;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        op_i         = OP_MUL;
        A_i          = '0;
        B_i          = '0;
        resp_ready_i = 1'b1;

        #3;
        checkOutput("rst_req_ready", req_ready_o, 1'b0);
        checkOutput("rst_resp_valid", resp_valid_o, 1'b0);
        checkOutput("rst_wb_value", writeback_value_o, 32'h0);
        checkOutput("rst_busy", busy_o, 1'b0);

        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        checkOutput("ready_at_release", req_ready_o, 1'b0);
        @(negedge clk_i);
        checkOutput("ready_after_edge", req_ready_o, 1'b1);

        $display("[TB] basic MUL latency and busy window");
        applyStimulus(OP_MUL, 32'd7, 32'd6, 32'h0000002A, FULL_LAT, c1);
        for (int i = 1; i <= 6; i++) begin
            checkOutput($sformatf("busy_c+%0d", i), busy_o, 1'b1);
            checkOutput($sformatf("ready_c+%0d", i), req_ready_o, 1'b0);
            if (i < 6) checkOutput($sformatf("valid_c+%0d", i), resp_valid_o, 1'b0);
            @(negedge clk_i);
        end
        checkOutput("busy_c+7", busy_o, 1'b0);
        checkOutput("ready_c+7", req_ready_o, 1'b1);
        drainResponses();

        $display("[TB] corner operands");
        applyStimulus(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL_LAT, c1);
        drainResponses();
        applyStimulus(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, HIT_LAT, c1);
        drainResponses();
        applyStimulus(OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, FULL_LAT, c1);
        drainResponses();
        applyStimulus(OP_MULH, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, FULL_LAT, c1);
        drainResponses();
        applyStimulus(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, FULL_LAT, c1);
        drainResponses();

        $display("[TB] backpressure");
        resp_ready_i = 1'b0;
        applyStimulus(OP_MUL, 32'h00001234, 32'h00000010, 32'h00012340, FULL_LAT, c1);
        for (int i = 0; i < 12 && !resp_valid_o; i++) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput("bp_valid", resp_valid_o, 1'b1);
            checkOutput("bp_value", writeback_value_o, 32'h00012340);
            checkOutput("bp_ready", req_ready_o, 1'b0);
        end
        @(posedge clk_i);
        #1 resp_ready_i = 1'b1;
        @(negedge clk_i);
        drainResponses();

        $display("[TB] reset during CALC");
        applyStimulus(OP_MULHU, 32'hDEADBEEF, 32'h12345678, 32'h0, FULL_LAT, c1);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        scoreboard.delete();
        #1;
        checkOutput("abort_busy", busy_o, 1'b0);
        checkOutput("abort_resp_valid", resp_valid_o, 1'b0);
        checkOutput("abort_wb_value", writeback_value_o, 32'h0);
        checkOutput("abort_req_ready", req_ready_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        checkOutput("abort_ready_release", req_ready_o, 1'b0);
        @(negedge clk_i);
        checkOutput("abort_ready_edge", req_ready_o, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("abort_no_resp", resp_valid_o, 1'b0);
            @(negedge clk_i);
        end

        $display("[TB] result reuse and signedness class");
        applyStimulus(OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, FULL_LAT, c1);
        drainResponses();
        applyStimulus(OP_MUL, 32'h00010000, 32'h00010000, 32'h00000000, HIT_LAT, c1);
        drainResponses();
        applyStimulus(OP_MULH, 32'h00010000, 32'h00010000, 32'h00000001, FULL_LAT, c1);
        drainResponses();

        $display("[TB] back-to-back requests");
        applyStimulus(OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, FULL_LAT, c1);
        applyStimulus(OP_MUL, 32'd3, 32'd5, 32'h0000000F, FULL_LAT, c2);
        checkOutput("b2b_accept_gap", c2 - c1, 7);
        drainResponses();

        $display("[TB] random operands");
        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i == 0) ra = 32'h80000000;
            if (i == 1) rb = 32'hFFFFFFFF;
            applyStimulus(rop, ra, rb, refModel(rop, ra, rb), FULL_LAT, c1);
            drainResponses();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
